// File: rtl/regn_pipe.sv
// Elastic valid/ready pipeline register: DEPTH stages of WIDTH bits with bubble
// collapsing, synchronous flush and a registered occupancy count.
module regn_pipe #(
    parameter int unsigned       WIDTH = 32,
    parameter int unsigned       DEPTH = 2,
    parameter logic [WIDTH-1:0]  INIT  = '0
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         flush,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [WIDTH-1:0]             in_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [WIDTH-1:0]             out_data,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int CW = $clog2(DEPTH + 1);

    logic [DEPTH-1:0] v_q, v_d;
    logic [WIDTH-1:0] d_q [DEPTH];
    logic [WIDTH-1:0] d_d [DEPTH];
    logic [CW-1:0]    count_q, count_d;

    logic [DEPTH-1:0] rdy;
    logic [DEPTH-1:0] src_v;
    logic [WIDTH-1:0] src_d [DEPTH];
    logic             in_fire;

    // A stage is ready if it or any stage downstream of it is empty, or the sink accepts.
    always_comb begin
        logic acc;
        // NOTE: blocking '=' in combinational logic; the scalar accumulator must see its own update.
        acc = out_ready;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            acc    = acc | ~v_q[i];
            rdy[i] = acc;
        end
    end

    assign in_ready = rdy[0] & ~flush;
    assign in_fire  = in_valid & in_ready;

    always_comb begin
        src_v[0] = in_fire;
        src_d[0] = in_data;
        for (int i = 1; i < DEPTH; i++) begin
            src_v[i] = v_q[i-1];
            src_d[i] = d_q[i-1];
        end
    end

    always_comb begin
        // NOTE: every output gets a hold default first so no path leaves it unassigned (no latch).
        v_d = v_q;
        for (int i = 0; i < DEPTH; i++) begin
            d_d[i] = d_q[i];
            if (rdy[i]) begin
                v_d[i] = src_v[i];
                if (src_v[i]) begin
                    d_d[i] = src_d[i];
                end
            end
        end

        // Flush empties the pipe but leaves the data registers untouched.
        if (flush) begin
            v_d = '0;
            for (int i = 0; i < DEPTH; i++) begin
                d_d[i] = d_q[i];
            end
        end

        count_d = '0;
        for (int i = 0; i < DEPTH; i++) begin
            count_d = count_d + CW'(v_d[i]);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v_q     <= '0;
            count_q <= '0;
            // NOTE: the data array is reset too, because out_data must read INIT straight after reset.
            for (int i = 0; i < DEPTH; i++) begin
                d_q[i] <= INIT;
            end
        end else begin
            v_q     <= v_d;
            count_q <= count_d;
            for (int i = 0; i < DEPTH; i++) begin
                d_q[i] <= d_d[i];
            end
        end
    end

    assign out_valid = v_q[DEPTH-1];
    assign out_data  = d_q[DEPTH-1];
    assign count     = count_q;

endmodule
